// File: rtl/alu_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// alu_muldiv_ctrl
//
// ALU control for the MIPS32 EX stage plus a sequential HI/LO unit.
//
// The combinational decoder turns the main-decoder class (aluop) and the
// R-format funct field into a 4-bit ALU op and a writeback source select.
// The HI/LO unit runs iterative MULT/MULTU (shift-add, one multiplier bit per
// cycle) and DIV/DIVU (restoring, one quotient bit per cycle). It also handles
// MTHI/MTLO. While an operation is in flight, any HI/LO-class instruction
// stalls the front end.
//
// Optional build macro:
//   MULDIV_EARLYOUT_EN - a multiply finishes as soon as the remaining
//                        multiplier bits are all zero (minimum one iteration).
//                        Divide latency is unaffected.
//
// Parameters:
//   WIDTH  datapath width of a, b, hi, lo (>= 4, even)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   valid     in   instruction in EX is valid this cycle
//   aluop     in   [2:0] main-decoder ALU class
//   func      in   [5:0] R-format funct field
//   a, b      in   [WIDTH-1:0] rs / rt operands
//   op        out  [3:0] ALU op (combinational, 4'hF when unrecognised)
//   illegal   out  unrecognised aluop/func while valid (combinational)
//   sel_hilo  out  [1:0] writeback source 0=ALU 1=HI 2=LO (combinational)
//   busy      out  muldiv FSM not idle (registered)
//   done      out  one-cycle pulse, hi/lo hold the new result (registered)
//   stall     out  hold the pipeline front end (combinational)
//   hi, lo    out  [WIDTH-1:0] HI / LO registers
// -----------------------------------------------------------------------------
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       aluop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       op,
    output logic             illegal,
    output logic [1:0]       sel_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Conditional two's-complement negate, single width.
    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x,
                                                input logic en);
        cneg_w = en ? (-x) : x;
    endfunction

    // Conditional two's-complement negate, double width (full product).
    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x,
                                                   input logic en);
        cneg_2w = en ? (-x) : x;
    endfunction

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    logic [1:0]         state_r;
    logic [1:0]         state_nx_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [CNT_W-1:0]   cnt_r;
    // MUL: shifted multiplicand.  DIV: divisor in the low half.
    logic [2*WIDTH-1:0] opb_r;
    // MUL: remaining multiplier.  DIV: dividend shifting out, quotient in.
    logic [WIDTH-1:0]   opq_r;
    // MUL: running product.  DIV: partial remainder in the low half.
    logic [2*WIDTH-1:0] acc_r;
    logic               is_div_r;
    logic               neg_lo_r;   // negate product (MUL) or quotient (DIV)
    logic               neg_hi_r;   // negate remainder (DIV)

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    logic [3:0] op_s;
    logic [1:0] sel_s;
    logic       known_s;

    // aluop/func to ALU op and writeback select.
    always_comb begin
        op_s    = 4'hF;
        sel_s   = 2'd0;
        known_s = 1'b0;
        case (aluop)
            3'b000: begin op_s = 4'd0; known_s = 1'b1; end
            3'b001: begin op_s = 4'd1; known_s = 1'b1; end
            3'b011: begin op_s = 4'd2; known_s = 1'b1; end
            3'b100: begin op_s = 4'd3; known_s = 1'b1; end
            3'b101: begin op_s = 4'd4; known_s = 1'b1; end
            3'b110: begin op_s = 4'd5; known_s = 1'b1; end
            3'b010: begin
                case (func)
                    6'h20, 6'h21: begin op_s = 4'd0; known_s = 1'b1; end
                    6'h22, 6'h23: begin op_s = 4'd1; known_s = 1'b1; end
                    6'h24:        begin op_s = 4'd2; known_s = 1'b1; end
                    6'h25:        begin op_s = 4'd3; known_s = 1'b1; end
                    6'h26:        begin op_s = 4'd5; known_s = 1'b1; end
                    6'h27:        begin op_s = 4'd6; known_s = 1'b1; end
                    6'h2A:        begin op_s = 4'd4; known_s = 1'b1; end
                    6'h2B:        begin op_s = 4'd7; known_s = 1'b1; end
                    6'h10: begin op_s = 4'd0; sel_s = 2'd1; known_s = 1'b1; end
                    6'h12: begin op_s = 4'd0; sel_s = 2'd2; known_s = 1'b1; end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        op_s    = 4'd0;
                        known_s = 1'b1;
                    end
                    default: begin
                        op_s    = 4'hF;
                        sel_s   = 2'd0;
                        known_s = 1'b0;
                    end
                endcase
            end
            default: begin
                op_s    = 4'hF;
                sel_s   = 2'd0;
                known_s = 1'b0;
            end
        endcase
    end

    assign op       = op_s;
    assign sel_hilo = sel_s;
    assign illegal  = valid & ~known_s;

    // ---------------------------------------------------------------------
    // HI/LO unit control
    // ---------------------------------------------------------------------
    logic is_r_s;
    logic md_s;         // MULT/MULTU/DIV/DIVU (funct 18..1B)
    logic hilo_s;       // MFHI/MTHI/MFLO/MTLO (funct 10..13)
    logic idle_s;
    logic start_s;
    logic mthi_s;
    logic mtlo_s;
    logic is_div_s;
    logic sgn_s;
    logic bzero_s;
    logic last_s;
    logic mul_end_s;

    assign is_r_s   = (aluop == 3'b010);
    assign md_s     = is_r_s & (func[5:2] == 4'b0110);
    assign hilo_s   = is_r_s & (func[5:2] == 4'b0100);
    assign idle_s   = (state_r == S_IDLE);
    assign start_s  = valid & md_s & idle_s;
    assign mthi_s   = valid & idle_s & is_r_s & (func == 6'h11);
    assign mtlo_s   = valid & idle_s & is_r_s & (func == 6'h13);
    // funct[1] selects divide, funct[0] selects the unsigned form.
    assign is_div_s = func[1];
    assign sgn_s    = ~func[0];
    assign bzero_s  = (b == {WIDTH{1'b0}});
    assign last_s   = (cnt_r == CNT_LAST);

`ifdef MULDIV_EARLYOUT_EN
    // Multiplier bits still to be consumed after this iteration.
    assign mul_end_s = last_s | (opq_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    assign mul_end_s = last_s;
`endif

    assign stall = busy_r & valid & (md_s | hilo_s);

    // ---------------------------------------------------------------------
    // Datapath combinational terms
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [2*WIDTH-1:0] mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Magnitudes; the most negative value maps onto itself, which is the
    // correct unsigned magnitude.
    assign a_abs_s = cneg_w(a, sgn_s & a[WIDTH-1]);
    assign b_abs_s = cneg_w(b, sgn_s & b[WIDTH-1]);

    assign mul_sum_s = opq_r[0] ? (acc_r + opb_r) : acc_r;

    // Restoring divide step: bring in the next dividend bit, subtract the
    // divisor when it fits. The difference fits in WIDTH bits whenever it is
    // taken, so the modular WIDTH-bit subtract is exact.
    assign div_shift_s = {acc_r[WIDTH-1:0], opq_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, opb_r[WIDTH-1:0]});
    assign div_rem_s   = div_ge_s ? (div_shift_s[WIDTH-1:0] - opb_r[WIDTH-1:0])
                                  : div_shift_s[WIDTH-1:0];

    // Sign correction applied in FIX. A divide by zero was loaded with
    // remainder=a, quotient=all ones and both negate flags clear.
    assign prod_s   = cneg_2w(acc_r, neg_lo_r);
    assign fix_hi_s = is_div_r ? cneg_w(acc_r[WIDTH-1:0], neg_hi_r)
                               : prod_s[2*WIDTH-1:WIDTH];
    assign fix_lo_s = is_div_r ? cneg_w(opq_r, neg_lo_r)
                               : prod_s[WIDTH-1:0];

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    // Next-state selection for the muldiv sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    if (is_div_s) begin
                        if (bzero_s) begin
                            state_nx_s = S_FIX;
                        end else begin
                            state_nx_s = S_DIV;
                        end
                    end else begin
                        state_nx_s = S_MUL;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_end_s) begin
                    state_nx_s = S_FIX;
                end else begin
                    state_nx_s = S_MUL;
                end
            end
            S_DIV: begin
                if (last_s) begin
                    state_nx_s = S_FIX;
                end else begin
                    state_nx_s = S_DIV;
                end
            end
            S_FIX:   state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // State, busy and done registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != S_IDLE);
            done_r  <= (state_r == S_FIX);
        end
    end

    // Operand load, iteration, HI/LO moves and result writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            opb_r    <= {(2*WIDTH){1'b0}};
            opq_r    <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        is_div_r <= is_div_s;
                        if (is_div_s && bzero_s) begin
                            opq_r    <= {WIDTH{1'b1}};
                            opb_r    <= {(2*WIDTH){1'b0}};
                            acc_r    <= {{WIDTH{1'b0}}, a};
                            neg_lo_r <= 1'b0;
                            neg_hi_r <= 1'b0;
                        end else if (is_div_s) begin
                            opq_r    <= a_abs_s;
                            opb_r    <= {{WIDTH{1'b0}}, b_abs_s};
                            acc_r    <= {(2*WIDTH){1'b0}};
                            neg_lo_r <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_r <= sgn_s & a[WIDTH-1];
                        end else begin
                            opq_r    <= b_abs_s;
                            opb_r    <= {{WIDTH{1'b0}}, a_abs_s};
                            acc_r    <= {(2*WIDTH){1'b0}};
                            neg_lo_r <= sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_r <= 1'b0;
                        end
                    end else if (mthi_s) begin
                        hi_r <= a;
                    end else if (mtlo_s) begin
                        lo_r <= a;
                    end else begin
                        hi_r <= hi_r;
                    end
                end
                S_MUL: begin
                    acc_r <= mul_sum_s;
                    opb_r <= {opb_r[2*WIDTH-2:0], 1'b0};
                    opq_r <= {1'b0, opq_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_ONE;
                end
                S_DIV: begin
                    acc_r <= {{WIDTH{1'b0}}, div_rem_s};
                    opq_r <= {opq_r[WIDTH-2:0], div_ge_s};
                    cnt_r <= cnt_r + CNT_ONE;
                end
                S_FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv_ctrl
//
// Self-checking bench for alu_muldiv_ctrl (WIDTH=32). A decode table is swept
// while the unit is held in reset, an arithmetic table is run through the
// HI/LO unit with latency/busy/result checks, and hand-written sequences cover
// MTHI/MTLO, stalling while busy and reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_alu_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [2:0]  aluop;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        illegal;
    logic [1:0]  sel_hilo;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    alu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .valid(valid), .aluop(aluop), .func(func),
        .a(a), .b(b), .op(op), .illegal(illegal), .sel_hilo(sel_hilo),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] aluop;
        logic [5:0] func;
        logic       chk_op;
        logic [3:0] op;
        logic       ill;
        logic [1:0] sel;
    } dvec_t;

    typedef struct {
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } avec_t;

    dvec_t dv[$];
    avec_t av[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected cycle (after the start edge) in which done is seen.
    function automatic int exp_latency(input logic [5:0] fn, input logic [31:0] bv);
`ifdef MULDIV_EARLYOUT_EN
        logic [31:0] m;
        int it;
`endif
        if (fn[1]) return (bv == 32'd0) ? 2 : 34;
`ifdef MULDIV_EARLYOUT_EN
        m  = (!fn[0] && bv[31]) ? (32'd0 - bv) : bv;
        it = 1;
        for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
        return it + 2;
`else
        return 34;
`endif
    endfunction

    // Issue one muldiv op (called just after a falling edge) and wait for done.
    task automatic run_op(input logic [5:0] fn, input logic [31:0] av_i,
                          input logic [31:0] bv_i, output int done_at,
                          output int busy_cnt, output logic busy_at_done,
                          output logic done_after);
        valid = 1'b1; aluop = 3'b010; func = fn; a = av_i; b = bv_i;
        @(posedge clk);
        done_at = -1; busy_cnt = 0; busy_at_done = 1'b1; done_after = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            valid = 1'b0;
            if (done) begin
                done_at = c;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (done_at > 0) begin
            @(negedge clk);
            done_after = done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d_at;
        int          b_cnt;
        int          s_cnt;
        int          lat;
        logic        b_done;
        logic        d_after;

        // Decode table: aluop, func, check op?, op, illegal, sel_hilo
        dv.push_back('{3'b000, 6'h00, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b001, 6'h00, 1'b1, 4'h1, 1'b0, 2'd0});
        dv.push_back('{3'b011, 6'h00, 1'b1, 4'h2, 1'b0, 2'd0});
        dv.push_back('{3'b100, 6'h00, 1'b1, 4'h3, 1'b0, 2'd0});
        dv.push_back('{3'b101, 6'h00, 1'b1, 4'h4, 1'b0, 2'd0});
        dv.push_back('{3'b110, 6'h3F, 1'b1, 4'h5, 1'b0, 2'd0});
        dv.push_back('{3'b111, 6'h20, 1'b1, 4'hF, 1'b1, 2'd0});
        dv.push_back('{3'b010, 6'h20, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h21, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h22, 1'b1, 4'h1, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h23, 1'b1, 4'h1, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h24, 1'b1, 4'h2, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h25, 1'b1, 4'h3, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h26, 1'b1, 4'h5, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h27, 1'b1, 4'h6, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h2A, 1'b1, 4'h4, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h2B, 1'b1, 4'h7, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h10, 1'b0, 4'h0, 1'b0, 2'd1});
        dv.push_back('{3'b010, 6'h12, 1'b0, 4'h0, 1'b0, 2'd2});
        dv.push_back('{3'b010, 6'h11, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h13, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h18, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h19, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h1A, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h1B, 1'b1, 4'h0, 1'b0, 2'd0});
        dv.push_back('{3'b010, 6'h3F, 1'b1, 4'hF, 1'b1, 2'd0});
        dv.push_back('{3'b010, 6'h00, 1'b1, 4'hF, 1'b1, 2'd0});
        dv.push_back('{3'b010, 6'h14, 1'b1, 4'hF, 1'b1, 2'd0});
        dv.push_back('{3'b010, 6'h28, 1'b1, 4'hF, 1'b1, 2'd0});

        // Arithmetic table: func, a, b, expected hi, expected lo
        av.push_back('{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
        av.push_back('{6'h18, 32'h00000005, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1});
        av.push_back('{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        av.push_back('{6'h18, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000000, 32'h00000010});
        av.push_back('{6'h19, 32'h00000007, 32'h00000003, 32'h00000000, 32'h00000015});
        av.push_back('{6'h18, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000});
        av.push_back('{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        av.push_back('{6'h1B, 32'd100,      32'd7,        32'h00000002, 32'h0000000E});
        av.push_back('{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        av.push_back('{6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        av.push_back('{6'h1A, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002});
        av.push_back('{6'h1B, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF});
        av.push_back('{6'h1A, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h00000000});
        av.push_back('{6'h1A, 32'd1234,     32'd0,        32'h000004D2, 32'hFFFFFFFF});
        av.push_back('{6'h1B, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});

        rst = 1'b1; valid = 1'b0; aluop = 3'b000; func = 6'h00;
        a = 32'd0; b = 32'd0;
        #12;
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_hi",    64'(hi),    64'd0);
        check("rst_lo",    64'(lo),    64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        // Decode sweep while held in reset so no muldiv op can start.
        valid = 1'b1;
        foreach (dv[i]) begin
            aluop = dv[i].aluop; func = dv[i].func;
            #1;
            if (dv[i].chk_op)
                check($sformatf("dec%0d_op", i), 64'(op), 64'(dv[i].op));
            check($sformatf("dec%0d_ill_sel", i), 64'({illegal, sel_hilo}),
                  64'({dv[i].ill, dv[i].sel}));
        end
        valid = 1'b0; aluop = 3'b010; func = 6'h3F;
        #1;
        check("dec_ill_novalid", 64'(illegal), 64'd0);

        @(negedge clk);
        rst = 1'b0;

        // Arithmetic table through the HI/LO unit.
        foreach (av[i]) begin
            run_op(av[i].func, av[i].a, av[i].b, d_at, b_cnt, b_done, d_after);
            lat = exp_latency(av[i].func, av[i].b);
            check($sformatf("ar%0d_lat", i),     64'(d_at),    64'(lat));
            check($sformatf("ar%0d_busycnt", i), 64'(b_cnt),   64'(lat - 1));
            check($sformatf("ar%0d_busydone", i),64'(b_done),  64'd0);
            check($sformatf("ar%0d_pulse", i),   64'(d_after), 64'd0);
            check($sformatf("ar%0d_hi", i),      64'(hi),      64'(av[i].hi));
            check($sformatf("ar%0d_lo", i),      64'(lo),      64'(av[i].lo));
        end

        // MTHI / MTLO from idle.
        valid = 1'b1; aluop = 3'b010; func = 6'h11; a = 32'hDEADBEEF;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        check("mthi_hi",   64'(hi),   64'hDEADBEEF);
        check("mthi_lo",   64'(lo),   64'hFFFFFFFF);
        check("mthi_busy", 64'(busy), 64'd0);
        valid = 1'b1; func = 6'h13; a = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        valid = 1'b0;
        check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
        check("mtlo_hi", 64'(hi), 64'hDEADBEEF);

        // Stall while busy: MULTU 3*4 in flight, then MULTU, MTHI, MFLO held.
        lat = exp_latency(6'h19, 32'd4);
        valid = 1'b1; aluop = 3'b010; func = 6'h19; a = 32'd3; b = 32'd4;
        @(posedge clk);
        d_at = -1; s_cnt = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                d_at = c;
                check("st_stall_done", 64'(stall),    64'd0);
                check("st_sel_done",   64'(sel_hilo), 64'd2);
                check("st_lo",         64'(lo),       64'd12);
                check("st_hi",         64'(hi),       64'd0);
                break;
            end
            if (stall) s_cnt++;
            if (c == 3) check("st_mthi_blocked", 64'(hi), 64'hDEADBEEF);
            if (c == 1) begin func = 6'h19; a = 32'd100; b = 32'd100; end
            if (c == 2) begin func = 6'h11; a = 32'h11111111; end
            if (c == 3) begin func = 6'h12; end
        end
        check("st_lat",  64'(d_at),  64'(lat));
        check("st_cnt",  64'(s_cnt), 64'(lat - 1));
        @(negedge clk);
        check("st_norestart", 64'(busy), 64'd0);
        check("st_lo_kept",   64'(lo),   64'd12);
        valid = 1'b0;

        // Asynchronous reset in the middle of a DIVU.
        valid = 1'b1; aluop = 3'b010; func = 6'h1B; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        check("mid_busy", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("rr_busy", 64'(busy), 64'd0);
        check("rr_done", 64'(done), 64'd0);
        check("rr_hi",   64'(hi),   64'd0);
        check("rr_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rr_after_busy", 64'(busy), 64'd0);
        check("rr_after_done", 64'(done), 64'd0);

        run_op(6'h19, 32'd7, 32'd3, d_at, b_cnt, b_done, d_after);
        check("rr_mul_lat", 64'(d_at), 64'(exp_latency(6'h19, 32'd3)));
        check("rr_mul_lo",  64'(lo),   64'h15);
        check("rr_mul_hi",  64'(hi),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
